// File: rtl/sdram_device_responder.sv
// SDR SDRAM chip-side responder: command decode, per-bank open row, reduced storage, CL/BL/DQM read pipeline.
// Define SDRAM_DEVICE_RESPONDER_TIMING_CHECK_EN to enable tRCD/tRP checking on err[2].
module sdram_device_responder #(
  parameter int unsigned ROW_USE_BITS = 4,
  parameter int unsigned COL_BITS     = 9,
  parameter int unsigned T_RCD        = 2,
  parameter int unsigned T_RP         = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SDRAM_CKE,
  input  logic        SDRAM_CS_N,
  input  logic        SDRAM_RAS_N,
  input  logic        SDRAM_CAS_N,
  input  logic        SDRAM_WE_N,
  input  logic [12:0] SDRAM_A,
  input  logic [1:0]  SDRAM_BA,
  inout  wire  [15:0] SDRAM_DQ,
  input  logic        SDRAM_DQML,
  input  logic        SDRAM_DQMH,
  output logic        mode_valid,
  output logic [3:0]  err
);

  localparam int unsigned ADDR_W = 2 + ROW_USE_BITS + COL_BITS;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef enum logic [2:0] {
    CMD_LMR = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_BST = 3'b110,
    CMD_NOP = 3'b111
  } cmd_e;

  typedef enum logic [1:0] {B_IDLE, B_READ, B_WRITE} burst_state_e;

  burst_state_e burst_state_q, burst_state_d;
  logic [1:0]              bur_ba_q, bur_ba_d;
  logic [ROW_USE_BITS-1:0] bur_row_q, bur_row_d;
  logic [COL_BITS-1:0]     bur_col_q, bur_col_d;
  logic [2:0]              bur_beat_q, bur_beat_d;
  logic                    bur_ap_q, bur_ap_d;
  logic [3:0]              bank_act_q, bank_act_d;
  logic [ROW_USE_BITS-1:0] bank_row_q [4];
  logic [ROW_USE_BITS-1:0] bank_row_d [4];
  logic [2:0]              cl_q, cl_d;
  logic [3:0]              bl_q, bl_d;
  logic                    mode_valid_q, mode_valid_d;
  logic [3:0]              err_q, err_d;
  logic [1:0]              pipe_vld_q, pipe_vld_d;
  logic [15:0]             pipe_dat_q [2];
  logic [15:0]             pipe_dat_d [2];
  logic                    dqm_q, dqm_d;
  logic                    dq_oe_q, dq_oe_d;
  logic [15:0]             dq_out_q, dq_out_d;

  logic [15:0]       mem_q [DEPTH];
  cmd_e              cmd_c;
  logic              cmd_en_c;
  logic              rw_go_c, rw_wr_c, bst_c;
  logic              beat_go_c, beat_wr_c;
  logic [ADDR_W-1:0] beat_addr_c;
  logic [15:0]       rd_data_c;
  logic [2:0]        last_beat_c;
  logic              tviol_c;
  logic              unused_a;

  assign cmd_c       = cmd_e'({SDRAM_RAS_N, SDRAM_CAS_N, SDRAM_WE_N});
  assign cmd_en_c    = SDRAM_CKE && !SDRAM_CS_N;
  assign rd_data_c   = mem_q[beat_addr_c];
  assign last_beat_c = 3'(bl_q - 4'd1);
  assign unused_a    = ^SDRAM_A;

  assign SDRAM_DQ   = dq_oe_q ? dq_out_q : 16'bz;
  assign mode_valid = mode_valid_q;
  assign err        = err_q;

  // Sequential burst order wrapping inside the BL-aligned column block.
  function automatic logic [COL_BITS-1:0] beat_col(input logic [COL_BITS-1:0] start,
                                                   input logic [2:0] k, input logic [3:0] bl);
    logic [COL_BITS-1:0] mask;
    mask     = COL_BITS'(bl - 4'd1);
    beat_col = (start & ~mask) | ((start + COL_BITS'(k)) & mask);
  endfunction

  always_comb begin
    burst_state_d = burst_state_q;
    bur_ba_d      = bur_ba_q;
    bur_row_d     = bur_row_q;
    bur_col_d     = bur_col_q;
    bur_beat_d    = bur_beat_q;
    bur_ap_d      = bur_ap_q;
    bank_act_d    = bank_act_q;
    bank_row_d    = bank_row_q;
    cl_d          = cl_q;
    bl_d          = bl_q;
    mode_valid_d  = mode_valid_q;
    err_d         = err_q;
    pipe_vld_d    = pipe_vld_q;
    pipe_dat_d    = pipe_dat_q;
    dqm_d         = dqm_q;
    dq_oe_d       = dq_oe_q;
    dq_out_d      = dq_out_q;
    rw_go_c       = 1'b0;
    rw_wr_c       = 1'b0;
    bst_c         = 1'b0;
    beat_go_c     = 1'b0;
    beat_wr_c     = 1'b0;
    beat_addr_c   = '0;

    if (tviol_c) err_d[2] = 1'b1;

    if (SDRAM_CKE) begin
      // DQM sampled here masks the driver update one edge later (read latency 2).
      dqm_d         = SDRAM_DQML | SDRAM_DQMH;
      dq_oe_d       = pipe_vld_q[0] && !dqm_q;
      dq_out_d      = pipe_dat_q[0];
      pipe_vld_d    = {1'b0, pipe_vld_q[1]};
      pipe_dat_d[0] = pipe_dat_q[1];

      if (!SDRAM_CS_N) begin
        case (cmd_c)
          CMD_ACT: begin
            if (bank_act_q[SDRAM_BA]) begin
              err_d[1] = 1'b1;
            end else begin
              bank_act_d[SDRAM_BA] = 1'b1;
              bank_row_d[SDRAM_BA] = SDRAM_A[ROW_USE_BITS-1:0];
            end
          end
          CMD_RD, CMD_WR: begin
            if (!bank_act_q[SDRAM_BA]) begin
              err_d[0] = 1'b1;
            end else begin
              rw_go_c = 1'b1;
              rw_wr_c = (cmd_c == CMD_WR);
            end
          end
          CMD_PRE: begin
            if (SDRAM_A[10]) bank_act_d = '0;
            else             bank_act_d[SDRAM_BA] = 1'b0;
          end
          CMD_LMR: begin
            if ((SDRAM_A[6:4] == 3'd2 || SDRAM_A[6:4] == 3'd3) && !SDRAM_A[2]) begin
              cl_d         = SDRAM_A[6:4];
              bl_d         = 4'd1 << SDRAM_A[1:0];
              mode_valid_d = 1'b1;
            end else begin
              err_d[3] = 1'b1;
            end
          end
          CMD_BST: bst_c = 1'b1;
          default: ;
        endcase
      end

      // A new READ/WRITE truncates any running burst at this edge.
      if (rw_go_c) begin
        bur_ba_d    = SDRAM_BA;
        bur_row_d   = bank_row_q[SDRAM_BA];
        bur_col_d   = SDRAM_A[COL_BITS-1:0];
        bur_ap_d    = SDRAM_A[10];
        bur_beat_d  = 3'd1;
        beat_go_c   = 1'b1;
        beat_wr_c   = rw_wr_c;
        beat_addr_c = {SDRAM_BA, bank_row_q[SDRAM_BA], SDRAM_A[COL_BITS-1:0]};
        if (bl_q == 4'd1) begin
          burst_state_d = B_IDLE;
          if (SDRAM_A[10]) bank_act_d[SDRAM_BA] = 1'b0;
        end else begin
          burst_state_d = rw_wr_c ? B_WRITE : B_READ;
        end
        if (rw_wr_c) begin
          pipe_vld_d = '0;
          dq_oe_d    = 1'b0;
        end
      end else if (bst_c) begin
        burst_state_d = B_IDLE;
      end else if (burst_state_q != B_IDLE) begin
        beat_go_c   = 1'b1;
        beat_wr_c   = (burst_state_q == B_WRITE);
        beat_addr_c = {bur_ba_q, bur_row_q, beat_col(bur_col_q, bur_beat_q, bl_q)};
        bur_beat_d  = bur_beat_q + 3'd1;
        if (bur_beat_q >= last_beat_c) begin
          burst_state_d = B_IDLE;
          if (bur_ap_q) bank_act_d[bur_ba_q] = 1'b0;
        end
      end

      // Read beat enters the pipeline so the driver updates CL-1 edges after issue.
      if (beat_go_c && !beat_wr_c) begin
        if (cl_q == 3'd2) begin
          pipe_vld_d[0] = 1'b1;
          pipe_dat_d[0] = rd_data_c;
        end else begin
          pipe_vld_d[1] = 1'b1;
          pipe_dat_d[1] = rd_data_c;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_state_q <= B_IDLE;
      bur_ba_q      <= '0;
      bur_row_q     <= '0;
      bur_col_q     <= '0;
      bur_beat_q    <= '0;
      bur_ap_q      <= 1'b0;
      bank_act_q    <= '0;
      for (int b = 0; b < 4; b++) bank_row_q[b] <= '0;
      cl_q          <= 3'd3;
      bl_q          <= 4'd1;
      mode_valid_q  <= 1'b0;
      err_q         <= '0;
      pipe_vld_q    <= '0;
      pipe_dat_q[0] <= '0;
      pipe_dat_q[1] <= '0;
      dqm_q         <= 1'b0;
      dq_oe_q       <= 1'b0;
      dq_out_q      <= '0;
    end else begin
      burst_state_q <= burst_state_d;
      bur_ba_q      <= bur_ba_d;
      bur_row_q     <= bur_row_d;
      bur_col_q     <= bur_col_d;
      bur_beat_q    <= bur_beat_d;
      bur_ap_q      <= bur_ap_d;
      bank_act_q    <= bank_act_d;
      bank_row_q    <= bank_row_d;
      cl_q          <= cl_d;
      bl_q          <= bl_d;
      mode_valid_q  <= mode_valid_d;
      err_q         <= err_d;
      pipe_vld_q    <= pipe_vld_d;
      pipe_dat_q    <= pipe_dat_d;
      dqm_q         <= dqm_d;
      dq_oe_q       <= dq_oe_d;
      dq_out_q      <= dq_out_d;
    end
  end

  // Storage survives reset; byte lanes gated by DQM sampled at the write edge.
  always_ff @(posedge clk) begin
    if (rst_n && beat_go_c && beat_wr_c) begin
      if (!SDRAM_DQML) mem_q[beat_addr_c][7:0]  <= SDRAM_DQ[7:0];
      if (!SDRAM_DQMH) mem_q[beat_addr_c][15:8] <= SDRAM_DQ[15:8];
    end
  end

`ifdef SDRAM_DEVICE_RESPONDER_TIMING_CHECK_EN
  localparam int unsigned T_MAX  = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int unsigned TCNT_W = $clog2(T_MAX + 1) + 1;

  logic [TCNT_W-1:0] act_cnt_q [4];
  logic [TCNT_W-1:0] act_cnt_d [4];
  logic [TCNT_W-1:0] pre_cnt_q [4];
  logic [TCNT_W-1:0] pre_cnt_d [4];

  // Counters hold cycles elapsed since the last ACTIVE / PRECHARGE, saturating at T_MAX.
  always_comb begin
    tviol_c = 1'b0;
    for (int b = 0; b < 4; b++) begin
      act_cnt_d[b] = (act_cnt_q[b] >= TCNT_W'(T_MAX)) ? act_cnt_q[b] : act_cnt_q[b] + 1'b1;
      pre_cnt_d[b] = (pre_cnt_q[b] >= TCNT_W'(T_MAX)) ? pre_cnt_q[b] : pre_cnt_q[b] + 1'b1;
    end
    if (cmd_en_c) begin
      case (cmd_c)
        CMD_ACT: begin
          if (!bank_act_q[SDRAM_BA]) begin
            if (pre_cnt_q[SDRAM_BA] < TCNT_W'(T_RP)) tviol_c = 1'b1;
            act_cnt_d[SDRAM_BA] = TCNT_W'(1);
          end
        end
        CMD_RD, CMD_WR: begin
          if (bank_act_q[SDRAM_BA] && act_cnt_q[SDRAM_BA] < TCNT_W'(T_RCD)) tviol_c = 1'b1;
        end
        CMD_PRE: begin
          for (int b = 0; b < 4; b++) begin
            if (SDRAM_A[10] || SDRAM_BA == 2'(b)) pre_cnt_d[b] = TCNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 4; b++) begin
        act_cnt_q[b] <= TCNT_W'(T_MAX);
        pre_cnt_q[b] <= TCNT_W'(T_MAX);
      end
    end else begin
      act_cnt_q <= act_cnt_d;
      pre_cnt_q <= pre_cnt_d;
    end
  end
`else
  logic unused_timing;
  assign tviol_c       = 1'b0;
  assign unused_timing = ^{T_RCD, T_RP};
`endif

endmodule

// File: tb/tb_sdram_device_responder.sv
// Directed bench for sdram_device_responder: mode load, write/read bursts, DQM masking, errors, reset mid-burst.
module tb_sdram_device_responder;

  localparam logic [2:0] C_LMR = 3'b000;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_BST = 3'b110;
  localparam logic [2:0] C_NOP = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cke, cs_n, ras_n, cas_n, we_n, dqml, dqmh;
  logic [12:0] a;
  logic [1:0]  ba;
  logic        mode_valid;
  logic [3:0]  err;
  logic [15:0] tb_dq;
  logic        tb_dq_oe;
  wire  [15:0] dq;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pullup pu_dq (dq);
  assign dq = tb_dq_oe ? tb_dq : 16'bz;

  sdram_device_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .SDRAM_CKE  (cke),
    .SDRAM_CS_N (cs_n),
    .SDRAM_RAS_N(ras_n),
    .SDRAM_CAS_N(cas_n),
    .SDRAM_WE_N (we_n),
    .SDRAM_A    (a),
    .SDRAM_BA   (ba),
    .SDRAM_DQ   (dq),
    .SDRAM_DQML (dqml),
    .SDRAM_DQMH (dqmh),
    .mode_valid (mode_valid),
    .err        (err)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Drive one command cycle from a negedge; returns at the following negedge.
  task automatic cmd(input logic [2:0] c, input logic [1:0] b, input logic [12:0] addr,
                     input logic ml, input logic mh, input logic oe, input logic [15:0] d);
    {ras_n, cas_n, we_n} = c;
    cs_n     = 1'b0;
    ba       = b;
    a        = addr;
    dqml     = ml;
    dqmh     = mh;
    tb_dq_oe = oe;
    tb_dq    = d;
    @(negedge clk);
  endtask

  task automatic nop();
    cmd(C_NOP, 2'd0, 13'd0, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  initial begin
    rst_n = 1'b0; cke = 1'b1; cs_n = 1'b1; ras_n = 1'b1; cas_n = 1'b1; we_n = 1'b1;
    a = '0; ba = '0; dqml = 1'b0; dqmh = 1'b0; tb_dq = '0; tb_dq_oe = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dq", dq, 16'hFFFF);
    chk("rst_mode_valid", {15'd0, mode_valid}, 16'h0000);
    chk("rst_err", {12'd0, err}, 16'h0000);
    rst_n = 1'b1;
    nop();

    // CL3 BL1 write/read
    cmd(C_LMR, 2'd0, 13'h030, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("lmr_mode_valid", {15'd0, mode_valid}, 16'h0001);
    cmd(C_ACT, 2'd0, 13'h000, 1'b0, 1'b0, 1'b0, 16'h0);
    nop();
    cmd(C_WR, 2'd0, 13'd5, 1'b0, 1'b0, 1'b1, 16'hBEEF);
    cmd(C_WR, 2'd0, 13'd4, 1'b0, 1'b0, 1'b1, 16'hA5C3);
    cmd(C_RD, 2'd0, 13'd5, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("cl3_r1", dq, 16'hFFFF);
    nop(); chk("cl3_r2", dq, 16'hFFFF);
    nop(); chk("cl3_r3", dq, 16'hBEEF);
    nop(); chk("cl3_r4", dq, 16'hFFFF);

    // CL2 BL4 write with DQMH on beat 2, then read back with wrap
    cmd(C_LMR, 2'd0, 13'h022, 1'b0, 1'b0, 1'b0, 16'h0);
    cmd(C_WR,  2'd0, 13'd6, 1'b0, 1'b0, 1'b1, 16'h0001);
    cmd(C_NOP, 2'd0, 13'd0, 1'b0, 1'b0, 1'b1, 16'h0002);
    cmd(C_NOP, 2'd0, 13'd0, 1'b0, 1'b1, 1'b1, 16'h0003);
    cmd(C_NOP, 2'd0, 13'd0, 1'b0, 1'b0, 1'b1, 16'h0004);
    cmd(C_RD,  2'd0, 13'd6, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("bl4_r1", dq, 16'hFFFF);
    nop(); chk("bl4_b0", dq, 16'h0001);
    nop(); chk("bl4_b1", dq, 16'h0002);
    nop(); chk("bl4_b2", dq, 16'hA503);
    nop(); chk("bl4_b3", dq, 16'h0004);
    nop(); chk("bl4_end", dq, 16'hFFFF);

    // DQML at R+1 hides the beat sampled at R+3
    cmd(C_RD,  2'd0, 13'd6, 1'b0, 1'b0, 1'b0, 16'h0);
    cmd(C_NOP, 2'd0, 13'd0, 1'b1, 1'b0, 1'b0, 16'h0);
    chk("dqm_b0", dq, 16'h0001);
    nop(); chk("dqm_b1_masked", dq, 16'hFFFF);
    nop(); chk("dqm_b2", dq, 16'hA503);
    nop(); chk("dqm_b3", dq, 16'h0004);
    nop(); chk("dqm_end", dq, 16'hFFFF);

    // Burst terminate after the first beat
    cmd(C_RD,  2'd0, 13'd6, 1'b0, 1'b0, 1'b0, 16'h0);
    cmd(C_BST, 2'd0, 13'd0, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("bst_b0", dq, 16'h0001);
    nop(); chk("bst_b1_none", dq, 16'hFFFF);
    nop();

    // Error flags
    cmd(C_RD, 2'd1, 13'd0, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("idle_rd_err", {12'd0, err}, 16'h0001);
    nop(); nop();
    chk("idle_rd_dq", dq, 16'hFFFF);
    cmd(C_ACT, 2'd0, 13'h001, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("act_active_err", {12'd0, err}, 16'h0003);
    cmd(C_LMR, 2'd0, 13'h050, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("bad_mode_err", {12'd0, err}, 16'h000B);
    chk("bad_mode_valid", {15'd0, mode_valid}, 16'h0001);
    cmd(C_RD, 2'd0, 13'd5, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("cl_kept_r1", dq, 16'hFFFF);
    nop(); chk("cl_kept_b0", dq, 16'h0004);
    nop(); chk("cl_kept_b1", dq, 16'h0001);
    nop(); nop(); nop();

    // Reset during beat 1 of a BL8 read
    cmd(C_LMR, 2'd0, 13'h023, 1'b0, 1'b0, 1'b0, 16'h0);
    cmd(C_RD,  2'd0, 13'd4, 1'b0, 1'b0, 1'b0, 16'h0);
    nop(); chk("bl8_b0", dq, 16'hA503);
    nop(); chk("bl8_b1", dq, 16'h0004);
    rst_n = 1'b0;
    #1;
    chk("midrst_dq", dq, 16'hFFFF);
    chk("midrst_mode_valid", {15'd0, mode_valid}, 16'h0000);
    chk("midrst_err", {12'd0, err}, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nop();
    cmd(C_ACT, 2'd0, 13'h000, 1'b0, 1'b0, 1'b0, 16'h0);
    nop();
    cmd(C_RD, 2'd0, 13'd6, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("post_rst_r1", dq, 16'hFFFF);
    nop(); chk("post_rst_r2", dq, 16'hFFFF);
    nop(); chk("post_rst_r3", dq, 16'h0001);
    nop(); chk("post_rst_r4", dq, 16'hFFFF);
    chk("post_rst_err", {12'd0, err}, 16'h0000);
    chk("post_rst_mode_valid", {15'd0, mode_valid}, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
